// File: rtl/fan_mode_ctrl_if.sv
// Button/tick inputs and mode outputs of the fan mode controller.
// master drives buttons and the 1 Hz tick; slave is the controller itself.
interface fan_mode_ctrl_if #(
   parameter int CNT_W = 7
);
   logic             tick_1hz;
   logic             power_on;
   logic             menu_btn;
   logic             mode1_btn;
   logic             mode2_btn;
   logic             mode3_btn;
   logic [2:0]       mode_state;
   logic [CNT_W-1:0] countdown_sec;
   logic             countdown_active;
   logic             hurricane_used;
   logic             menu_open;

   modport master (
      output tick_1hz, power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn,
      input  mode_state, countdown_sec, countdown_active, hurricane_used, menu_open
   );

   modport slave (
      input  tick_1hz, power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn,
      output mode_state, countdown_sec, countdown_active, hurricane_used, menu_open
   );
endinterface

// File: rtl/fan_mode_ctrl.sv
// Hood fan gear FSM: button edges -> standby/gear1/gear2/hurricane/purge with countdowns.
// Press-to-mode_state latency 2 cycles (edge reg + state reg); no backpressure, events never stall.
module fan_mode_ctrl #(
   parameter int HURRICANE_SECS = 60,
   parameter int PURGE_SECS     = 60,
   parameter int CNT_W          = 7
) (
   input  logic           clk,
   input  logic           rst,
   fan_mode_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_OFF,
      S_STANDBY,
      S_GEAR1,
      S_GEAR2,
      S_HURR,
      S_PURGE
   } state_t;

   localparam logic [CNT_W-1:0] HURR_LOAD  = CNT_W'(HURRICANE_SECS);
   localparam logic [CNT_W-1:0] PURGE_LOAD = CNT_W'(PURGE_SECS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             used_q, used_nxt;
   logic             menu_q, menu_nxt;
   logic [2:0]       mode_q;
   logic             act_q;

   // Bit order {menu, mode3, mode2, mode1} doubles as press priority order.
   logic [3:0] btn_lvl;
   logic [3:0] btn_prev;
   logic [3:0] press_q;
   logic       p_menu, p_m3, p_m2, p_m1;

   assign btn_lvl = {bus.menu_btn, bus.mode3_btn, bus.mode2_btn, bus.mode1_btn};

   // Previous levels reset high so a button held through reset is not a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev <= 4'hF;
         press_q  <= 4'h0;
      end else begin
         btn_prev <= btn_lvl;
         press_q  <= btn_lvl & ~btn_prev;
      end
   end

   always_comb begin
      p_menu = press_q[3];
      p_m3   = press_q[2] & ~press_q[3];
      p_m2   = press_q[1] & ~press_q[3] & ~press_q[2];
      p_m1   = press_q[0] & ~press_q[3] & ~press_q[2] & ~press_q[1];
   end

   function automatic logic [2:0] mode_enc(input state_t s);
      case (s)
         S_GEAR1: mode_enc = 3'd1;
         S_GEAR2: mode_enc = 3'd2;
         S_HURR:  mode_enc = 3'd3;
         S_PURGE: mode_enc = 3'd4;
         default: mode_enc = 3'd0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         used_q  <= 1'b0;
         menu_q  <= 1'b0;
         mode_q  <= 3'd0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         used_q  <= used_nxt;
         menu_q  <= menu_nxt;
         mode_q  <= mode_enc(state_nxt);
         act_q   <= (state_nxt == S_HURR) || (state_nxt == S_PURGE);
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      used_nxt  = used_q;
      menu_nxt  = menu_q;
      // Power loss overrides any pending press or tick.
      if (!bus.power_on) begin
         state_nxt = S_OFF;
         cnt_nxt   = '0;
         used_nxt  = 1'b0;
         menu_nxt  = 1'b0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_nxt = S_STANDBY;
            end
            S_STANDBY: begin
               if (p_menu) begin
                  menu_nxt = ~menu_q;
               end else if (menu_q) begin
                  if (p_m3 && !used_q) begin
                     state_nxt = S_HURR;
                     cnt_nxt   = HURR_LOAD;
                     used_nxt  = 1'b1;
                     menu_nxt  = 1'b0;
                  end else if (p_m2) begin
                     state_nxt = S_GEAR2;
                     menu_nxt  = 1'b0;
                  end else if (p_m1) begin
                     state_nxt = S_GEAR1;
                     menu_nxt  = 1'b0;
                  end
               end
            end
            S_GEAR1, S_GEAR2: begin
               if (p_menu) begin
                  state_nxt = S_STANDBY;
               end else if (p_m2) begin
                  state_nxt = S_GEAR2;
               end else if (p_m1) begin
                  state_nxt = S_GEAR1;
               end
            end
            S_HURR: begin
               // A press-driven reload is never decremented by a coincident tick.
               if (p_menu) begin
                  state_nxt = S_PURGE;
                  cnt_nxt   = PURGE_LOAD;
               end else if (bus.tick_1hz) begin
                  if (cnt_q == CNT_ONE) begin
                     state_nxt = S_GEAR2;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_q - CNT_ONE;
                  end
               end
            end
            S_PURGE: begin
               if (bus.tick_1hz) begin
                  if (cnt_q == CNT_ONE) begin
                     state_nxt = S_STANDBY;
                     cnt_nxt   = '0;
                     menu_nxt  = 1'b0;
                  end else begin
                     cnt_nxt = cnt_q - CNT_ONE;
                  end
               end
            end
            default: begin
               state_nxt = S_OFF;
               cnt_nxt   = '0;
               menu_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign bus.mode_state       = mode_q;
   assign bus.countdown_sec    = cnt_q;
   assign bus.countdown_active = act_q;
   assign bus.hurricane_used   = used_q;
   assign bus.menu_open        = menu_q;

endmodule

// File: doc/fan_mode_ctrl.md
Name: fan_mode_ctrl

Overview:
- Upstream stage of the kitchen-hood smoker timer block. Produces the 3-bit `mode_state` that the timer block consumes.
- Turns button levels into press events, then runs the gear state machine: standby, gear 1, gear 2, one-shot hurricane, and exit purge.
- Owns every mode countdown: the hurricane auto-downgrade to gear 2, and the purge delay before standby.
- Sits between the button debouncers / 1 Hz divider and the smoker timer/display path.

Parameters:
HURRICANE_SECS, 60, hurricane duration in seconds before auto-switch to gear 2
PURGE_SECS, 60, exit-purge duration in seconds before standby
CNT_W, 7, countdown width; must hold max(HURRICANE_SECS, PURGE_SECS)

Ports:
clk  input  1  system clock (one clock domain)
rst  input  1  asynchronous active-high reset
tick_1hz  input  1  one-cycle pulse once per second, synchronous to clk
power_on  input  1  level; low forces OFF and clears the hurricane-used flag
menu_btn  input  1  debounced level, active-high
mode1_btn  input  1  debounced level, active-high
mode2_btn  input  1  debounced level, active-high
mode3_btn  input  1  debounced level, active-high
mode_state  output  3  0=standby/off, 1=gear1, 2=gear2, 3=hurricane, 4=purge
countdown_sec  output  CNT_W  remaining seconds in HURRICANE/PURGE; 0 otherwise
countdown_active  output  1  high in HURRICANE and PURGE
hurricane_used  output  1  hurricane consumed this power session
menu_open  output  1  standby menu armed

Behaviour:
- Reset: clock domain is one clock; reset is asynchronous, active-high (`rst`), acting on `clk`-domain flops.
- Reset values: state=OFF, mode_state=0, countdown_sec=0, countdown_active=0, hurricane_used=0, menu_open=0.
- Reset values, button history: all previous-level registers=1, so a button held through reset yields no press.
- Press detection: press = level & ~prev_level, registered. One press per rising edge, regardless of hold length.
- Press priority: if several presses occur in one cycle, only the highest-priority one acts: menu > mode3 > mode2 > mode1.
- Outputs are registered. A press in cycle N is visible on mode_state in cycle N+2 (edge register plus state register).
- States: OFF, STANDBY, GEAR1, GEAR2, HURRICANE, PURGE.
- OFF: power_on=1 -> STANDBY. All presses ignored.
- power_on=0 in any state: next cycle goes to OFF, clears hurricane_used, menu_open and countdown_sec. This overrides every press and tick.
- STANDBY, menu press: toggles menu_open.
- STANDBY, menu_open=1: mode1 -> GEAR1; mode2 -> GEAR2; mode3 -> HURRICANE only if hurricane_used=0, otherwise ignored with menu_open kept at 1.
- STANDBY, menu_open=0: gear presses ignored.
- menu_open is cleared on any transition out of STANDBY.
- GEAR1/GEAR2: mode1/mode2 switch directly between gears. Menu press -> STANDBY at once. mode3 ignored.
- HURRICANE entry: countdown_sec=HURRICANE_SECS; hurricane_used=1 (sticky until reset or power_on low).
- HURRICANE, each tick: countdown_sec decrements. Tick with countdown_sec==1 -> GEAR2 with countdown_sec=0.
- HURRICANE, menu press: -> PURGE with countdown_sec=PURGE_SECS. Gear presses ignored.
- PURGE: all buttons ignored except power_on. Each tick decrements. Tick with countdown_sec==1 -> STANDBY with countdown_sec=0 and menu_open=0.
- Press and tick in the same cycle: the press transition wins, and the tick does not decrement the newly loaded value.
- Countdown never underflows; 0 is only held outside HURRICANE/PURGE.
- Ticks in STANDBY/GEAR1/GEAR2/OFF have no effect.
- mode_state encoding: 3'b101..3'b111 are never driven.

Test Plan:
- Reset asserted mid-HURRICANE (countdown_sec=37) with mode2_btn held -> all outputs 0; after release no GEAR2 entry until mode2_btn drops and rises again.
- power_on=1, menu press, mode1 press, mode2 press, menu press -> mode_state 0,1,2,0; menu_open 1 after first press, 0 after gear entry.
- STANDBY menu, mode3 -> mode_state=3, countdown_sec=60; 60 ticks -> mode_state=2, countdown_sec=0, hurricane_used=1; menu, mode3 again -> stays 0 with menu_open=1.
- HURRICANE at countdown 25, menu press -> mode_state=4, countdown_sec=60; mode1/2/3 presses ignored; 60 ticks -> mode_state=0.
- Same-cycle menu+mode1 in GEAR2 -> STANDBY. Menu press coincident with tick at HURRICANE countdown=1 -> PURGE with countdown 60 (not GEAR2).
- power_on dropped during PURGE -> OFF next cycle, hurricane_used=0. Re-power, menu, mode3 -> HURRICANE allowed again.
